// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM fill controller: FSM state encoding and an index-width helper.
package cam_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP,
    FLUSH
  } state_t;

  // Bits needed to index n entries; never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_victim_sel.sv
// Victim slot choice: lowest-index free slot, or the round-robin pointer once every slot is valid.
module cam_victim_sel
  import cam_ctrl_pkg::*;
#(
  parameter int WORDS     = 8,
  parameter int ADDR_LEFT = idx_width(WORDS) - 1
) (
  input  logic [WORDS-1:0]  valid,
  input  logic [ADDR_LEFT:0] rr_ptr,
  output logic [ADDR_LEFT:0] victim,
  output logic               all_valid
);

  localparam int AW = ADDR_LEFT + 1;

  logic [ADDR_LEFT:0] free_idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    free_idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = AW'(i);
    end
    all_valid = &valid;
    victim    = all_valid ? rr_ptr : free_idx;
  end

endmodule

// File: rtl/cam_fill_ctrl.sv
// Sequencing controller in front of the CAM: lookup, miss fetch and fill, and full-cache flush.
module cam_fill_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int TAG_SZ    = 8,
  parameter int ADDR_LEFT = idx_width(WORDS) - 1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TAG_SZ-1:0]   req_tag,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                rsp_valid,
  output logic                rsp_hit,
  output logic [BITS-1:0]     rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [TAG_SZ-1:0]   mem_req_tag,
  input  logic                mem_rsp_valid,
  input  logic [BITS-1:0]     mem_rsp_data,
  output logic                cam_read,
  output logic [TAG_SZ-1:0]   cam_check_tag,
  input  logic                cam_found,
  input  logic [BITS-1:0]     cam_data,
  input  logic                cam_full,
  output logic                cam_write_,
  output logic [ADDR_LEFT:0]  cam_w_addr,
  output logic [BITS-1:0]     cam_wdata,
  output logic [TAG_SZ-1:0]   cam_new_tag,
  output logic                cam_new_valid
);

  localparam int AW = ADDR_LEFT + 1;

  state_t              state;
  logic                idle_q;
  logic [TAG_SZ-1:0]   tag_q;
  logic [BITS-1:0]     data_q;
  logic                hit_q;
  logic [WORDS-1:0]    shadow_valid;
  logic [ADDR_LEFT:0]  rr_ptr;
  logic [ADDR_LEFT:0]  flush_cnt;
  logic [ADDR_LEFT:0]  victim;
  logic                all_valid;

  cam_victim_sel #(
    .WORDS     (WORDS),
    .ADDR_LEFT (ADDR_LEFT)
  ) u_victim_sel (
    .valid     (shadow_valid),
    .rr_ptr    (rr_ptr),
    .victim    (victim),
    .all_valid (all_valid)
  );

  // A pending flush wins over a lookup, so the request is refused in that same cycle.
  assign req_ready = idle_q & ~flush_req;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state         <= IDLE;
      idle_q        <= 1'b1;
      tag_q         <= '0;
      data_q        <= '0;
      hit_q         <= 1'b0;
      shadow_valid  <= '0;
      rr_ptr        <= '0;
      flush_cnt     <= '0;
      flush_done    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_tag   <= '0;
      cam_read      <= 1'b0;
      cam_check_tag <= '0;
      cam_write_    <= 1'b1;
      cam_w_addr    <= '0;
      cam_wdata     <= '0;
      cam_new_tag   <= '0;
      cam_new_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      // Outputs default to their quiet values; each branch re-asserts what the next state drives.
      idle_q        <= 1'b0;
      flush_done    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_tag   <= '0;
      cam_read      <= 1'b0;
      cam_check_tag <= '0;
      cam_write_    <= 1'b1;
      cam_w_addr    <= '0;
      cam_wdata     <= '0;
      cam_new_tag   <= '0;
      cam_new_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (flush_req) begin
            state      <= FLUSH;
            flush_cnt  <= '0;
            cam_write_ <= 1'b0;
          end else if (req_valid) begin
            state         <= LOOKUP;
            tag_q         <= req_tag;
            cam_read      <= 1'b1;
            cam_check_tag <= req_tag;
          end else begin
            idle_q <= 1'b1;
          end
        end

        LOOKUP: begin
          if (cam_found) begin
            state     <= RESP;
            data_q    <= cam_data;
            hit_q     <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_data  <= cam_data;
          end else begin
            state         <= MISS_REQ;
            mem_req_valid <= 1'b1;
            mem_req_tag   <= tag_q;
          end
        end

        MISS_REQ: begin
          if (mem_req_ready) begin
            state <= MISS_WAIT;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_tag   <= tag_q;
          end
        end

        MISS_WAIT: begin
          if (mem_rsp_valid) begin
            state         <= FILL;
            data_q        <= mem_rsp_data;
            hit_q         <= 1'b0;
            cam_write_    <= 1'b0;
            cam_w_addr    <= victim;
            cam_wdata     <= mem_rsp_data;
            cam_new_tag   <= tag_q;
            cam_new_valid <= 1'b1;
          end
        end

        FILL: begin
          // Shadow state is stable since MISS_WAIT, so all_valid still describes this victim.
          shadow_valid[cam_w_addr] <= 1'b1;
          if (all_valid) rr_ptr <= (rr_ptr == AW'(WORDS - 1)) ? '0 : rr_ptr + 1'b1;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_hit   <= hit_q;
          rsp_data  <= data_q;
        end

        RESP: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end

        FLUSH: begin
          shadow_valid[flush_cnt] <= 1'b0;
          if (flush_cnt == AW'(WORDS - 1)) begin
            state      <= IDLE;
            idle_q     <= 1'b1;
            flush_done <= 1'b1;
            rr_ptr     <= '0;
          end else begin
            flush_cnt  <= flush_cnt + 1'b1;
            cam_write_ <= 1'b0;
            cam_w_addr <= flush_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

  // The shadow copy must agree with the CAM's own full flag once each write has landed.
  a_full_tracks: assert property (@(posedge clk) disable iff (!rst_)
    !$past(cam_write_) |-> ((&shadow_valid) == cam_full));

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Bench for cam_fill_ctrl: behavioural CAM and memory around the DUT, checked against a slot-level cache model.
module tb_cam_fill_ctrl;

  localparam int WORDS  = 8;
  localparam int BITS   = 8;
  localparam int TAG_SZ = 8;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst_;
  logic              req_valid, req_ready, flush_req, flush_done;
  logic [TAG_SZ-1:0] req_tag;
  logic              rsp_valid, rsp_hit;
  logic [BITS-1:0]   rsp_data;
  logic              mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [TAG_SZ-1:0] mem_req_tag;
  logic [BITS-1:0]   mem_rsp_data;
  logic              cam_read, cam_found, cam_full, cam_write_, cam_new_valid;
  logic [TAG_SZ-1:0] cam_check_tag, cam_new_tag;
  logic [BITS-1:0]   cam_data, cam_wdata;
  logic [AW-1:0]     cam_w_addr;

  int checks = 0;
  int errors = 0;

  cam_fill_ctrl #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAG_SZ), .ADDR_LEFT(AW - 1)) dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .flush_req(flush_req), .flush_done(flush_done),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .cam_read(cam_read), .cam_check_tag(cam_check_tag), .cam_found(cam_found),
    .cam_data(cam_data), .cam_full(cam_full), .cam_write_(cam_write_),
    .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata), .cam_new_tag(cam_new_tag),
    .cam_new_valid(cam_new_valid)
  );

  always #5 clk = ~clk;

  // Stand-in CAM: written only by the DUT, cleared by the shared reset.
  logic [WORDS-1:0]  cv;
  logic [TAG_SZ-1:0] ct [WORDS];
  logic [BITS-1:0]   cd [WORDS];

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cv <= '0;
      for (int i = 0; i < WORDS; i++) begin
        ct[i] <= '0;
        cd[i] <= '0;
      end
    end else if (!cam_write_) begin
      cv[cam_w_addr] <= cam_new_valid;
      ct[cam_w_addr] <= cam_new_tag;
      cd[cam_w_addr] <= cam_wdata;
    end
  end

  always_comb begin
    cam_found = 1'b0;
    cam_data  = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (!cam_found && cv[i] && ct[i] == cam_check_tag) begin
        cam_found = 1'b1;
        cam_data  = cd[i];
      end
    end
    cam_full = &cv;
  end

  // Reference model: which tag/data each slot holds, plus the replacement pointer.
  bit         m_valid [WORDS];
  logic [7:0] m_tag   [WORDS];
  logic [7:0] m_data  [WORDS];
  int         m_rr;

  function automatic void model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_rr = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_req_ready"},     req_ready, 1);
    check({p, "_cam_write_"},    cam_write_, 1);
    check({p, "_rsp_valid"},     rsp_valid, 0);
    check({p, "_rsp_data"},      rsp_data, 0);
    check({p, "_mem_req_valid"}, mem_req_valid, 0);
    check({p, "_mem_req_tag"},   mem_req_tag, 0);
    check({p, "_cam_read"},      cam_read, 0);
    check({p, "_cam_check_tag"}, cam_check_tag, 0);
    check({p, "_flush_done"},    flush_done, 0);
    check({p, "_cam_w_addr"},    cam_w_addr, 0);
    check({p, "_cam_new_valid"}, cam_new_valid, 0);
  endtask

  // One lookup from accept to response; memory delays and a spurious early response are configurable.
  task automatic run_req(input logic [7:0] tag, input logic [7:0] mdata,
                         input int rdly, input int vdly, input bit spurious);
    int hit_slot = -1, exp_slot = -1, exp_lat, cyc, rcnt = 0, wcnt = 0, n = 0;
    int lat = -1, n_wr = 0, w_addr = -1, mreq_cycles = 0, tag_errs = 0, rdy_errs = 0;
    bit all_v, phase_wait = 0, done = 0, req_hs, rsp_hs, mreq_pre;
    logic       got_hit = 1'bx, w_valid = 1'bx;
    logic [7:0] got_data = 'x, w_tag = 'x, w_data = 'x;
    string tn;
    tn = $sformatf("req%02h", tag);

    foreach (m_valid[i]) if (m_valid[i] && m_tag[i] == tag && hit_slot < 0) hit_slot = i;
    foreach (m_valid[i]) if (!m_valid[i] && exp_slot < 0) exp_slot = i;
    all_v = (exp_slot < 0);
    if (all_v) exp_slot = m_rr;
    exp_lat = (hit_slot >= 0) ? 2 : 5 + rdly + vdly;

    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1;
    req_tag   = tag;
    @(negedge clk);
    check({tn, "_accept_ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_tag   = 8'($urandom);

    cyc = 1;
    while (!done && cyc < 60) begin
      mem_req_ready = mem_req_valid && (rcnt >= rdly);
      mem_rsp_valid = phase_wait ? (wcnt >= vdly) : (spurious && mem_req_valid && !mem_req_ready);
      mem_rsp_data  = phase_wait ? mdata : ~mdata;
      @(negedge clk);
      if (req_ready) rdy_errs++;
      if (mem_req_valid) begin
        mreq_cycles++;
        if (mem_req_tag !== tag) tag_errs++;
      end
      if (cam_read && cam_check_tag !== tag) tag_errs++;
      if (!cam_write_) begin
        n_wr++;
        w_addr  = int'(cam_w_addr);
        w_tag   = cam_new_tag;
        w_data  = cam_wdata;
        w_valid = cam_new_valid;
      end
      if (rsp_valid) begin
        lat      = cyc;
        got_hit  = rsp_hit;
        got_data = rsp_data;
        done     = 1'b1;
      end
      mreq_pre = mem_req_valid;
      req_hs   = mem_req_valid && mem_req_ready;
      rsp_hs   = phase_wait && mem_rsp_valid;
      @(posedge clk); #1;
      if (rsp_hs) phase_wait = 1'b0;
      else if (phase_wait) wcnt++;
      if (req_hs) phase_wait = 1'b1;
      else if (mreq_pre) rcnt++;
      cyc++;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    check({tn, "_latency"},     lat, exp_lat);
    check({tn, "_hit"},         got_hit, (hit_slot >= 0));
    check({tn, "_data"},        got_data, (hit_slot >= 0) ? m_data[hit_slot] : mdata);
    check({tn, "_mreq_cycles"}, mreq_cycles, (hit_slot >= 0) ? 0 : rdly + 1);
    check({tn, "_tag_errs"},    tag_errs, 0);
    check({tn, "_ready_low"},   rdy_errs, 0);
    check({tn, "_writes"},      n_wr, (hit_slot >= 0) ? 0 : 1);
    if (hit_slot < 0) begin
      check({tn, "_fill_slot"},  w_addr, exp_slot);
      check({tn, "_fill_tag"},   w_tag, tag);
      check({tn, "_fill_data"},  w_data, mdata);
      check({tn, "_fill_valid"}, w_valid, 1);
      m_valid[exp_slot] = 1'b1;
      m_tag[exp_slot]   = tag;
      m_data[exp_slot]  = mdata;
      if (all_v) m_rr = (m_rr + 1) % WORDS;
    end
  endtask

  task automatic do_flush(input bit with_req, input logic [7:0] tag);
    int n_wr = 0, errs = 0, done_at = -1;
    logic [31:0] idx;
    flush_req = 1'b1;
    req_valid = with_req;
    req_tag   = tag;
    @(negedge clk);
    check("flush_req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    req_valid = 1'b0;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      @(negedge clk);
      if (!cam_write_) begin
        idx = n_wr;
        if (cam_w_addr !== idx[AW-1:0] || cam_new_valid !== 1'b0 ||
            cam_new_tag !== '0 || cam_wdata !== '0) errs++;
        n_wr++;
      end
      if (rsp_valid || cam_read || mem_req_valid) errs++;
      if (!flush_done && req_ready) errs++;
      if (flush_done) done_at = c;
      @(posedge clk); #1;
    end
    check("flush_writes", n_wr, WORDS);
    check("flush_errs", errs, 0);
    check("flush_done_cycle", done_at, WORDS);
    @(negedge clk);
    check("flush_done_pulse", flush_done, 0);
    @(posedge clk); #1;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_errs;
    rst_          = 1'b1;
    req_valid     = 1'b0;
    req_tag       = '0;
    flush_req     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    model_clear();
    #1 rst_ = 1'b0;
    #1 check_reset("in_reset");
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    @(posedge clk); #1;
    check_reset("after_reset");

    // First miss, then the same tag hits.
    run_req(8'h11, 8'hA5, 0, 0, 0);
    run_req(8'h11, 8'h00, 0, 0, 0);

    // Flush beats a simultaneous request; the old tag then misses.
    do_flush(1'b1, 8'h11);
    run_req(8'h11, 8'h3C, 0, 0, 0);

    // Fill every slot, then walk the round-robin pointer past its wrap.
    do_flush(1'b0, 8'h00);
    for (int i = 0; i < WORDS; i++) run_req(8'(8'h20 + i), 8'(8'h80 + i), 0, 0, 0);
    @(negedge clk);
    check("cam_full_after_fill", cam_full, 1);
    @(posedge clk); #1;
    for (int i = 0; i <= WORDS; i++) run_req(8'(8'h30 + i), 8'(8'hC0 + i), 0, 0, 0);

    // Slow memory with an early, out-of-protocol response that must be ignored.
    run_req(8'h40, 8'h5E, 3, 4, 1'b1);

    // Randomized traffic over a tag pool larger than the cache.
    for (int i = 0; i < 30; i++) begin
      run_req(8'(8'h50 + $urandom_range(0, 11)), 8'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for memory: request dropped, cache empty afterwards.
    req_valid = 1'b1;
    req_tag   = 8'h66;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_mreq_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 rst_ = 1'b0;
    #1 check_reset("rst_mid");
    quiet_errs = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid || !cam_write_) quiet_errs++;
    end
    @(posedge clk); #3;
    rst_ = 1'b1;
    model_clear();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 8'hEE;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || !cam_write_ || !req_ready) quiet_errs++;
    end
    check("rst_mid_quiet", quiet_errs, 0);
    @(posedge clk); #1;
    run_req(8'h67, 8'h77, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_fill_ctrl.md
Name: cam_fill_ctrl

Overview:
- Sequencing controller in front of the CAM cache; it is the CAM's only writer.
- Accepts one tag lookup at a time. On a hit it returns the CAM data. On a miss it fetches the line from backing memory, allocates a victim slot in the CAM, writes it, and returns the fetched data.
- Also performs a whole-cache flush by walking every slot and clearing its valid bit.

Parameters:
- WORDS, 8, number of CAM entries.
- BITS, 8, data width per entry.
- TAG_SZ, 8, tag width.
- ADDR_LEFT, $clog2(WORDS)-1, MSB of a slot index.

Ports:
- clk  input  1  system clock.
- rst_  input  1  asynchronous active-low reset.
- req_valid  input  1  lookup request.
- req_ready  output  1  controller can accept a request.
- req_tag  input  TAG_SZ  tag to look up.
- flush_req  input  1  request full invalidate; sampled only in IDLE.
- flush_done  output  1  one-cycle pulse when the flush completes.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_hit  output  1  1 = CAM hit, 0 = filled from memory.
- rsp_data  output  BITS  response data.
- mem_req_valid  output  1  fetch request to backing memory.
- mem_req_ready  input  1  memory accepts the fetch.
- mem_req_tag  output  TAG_SZ  tag being fetched.
- mem_rsp_valid  input  1  fetch data valid.
- mem_rsp_data  input  BITS  fetched data.
- cam_read  output  1  CAM read strobe.
- cam_check_tag  output  TAG_SZ  CAM search tag.
- cam_found  input  1  CAM found_it.
- cam_data  input  BITS  CAM data out.
- cam_full  input  1  CAM full flag; used for checking only.
- cam_write_  output  1  CAM write strobe, active low.
- cam_w_addr  output  ADDR_LEFT+1  CAM write slot.
- cam_wdata  output  BITS  CAM write data.
- cam_new_tag  output  TAG_SZ  CAM write tag.
- cam_new_valid  output  1  CAM valid bit to write.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tag_q, data_q, shadow valid vector, rr_ptr and flush counter all 0.
  - All outputs 0, except cam_write_=1 and req_ready=1.
  - A request in flight is dropped, with no response. The CAM clears on the same reset.
- IDLE: req_ready=1.
  - flush_req has priority: goes to FLUSH with counter=0, and req_ready is driven 0 that cycle.
  - Otherwise req_valid latches tag_q=req_tag and goes to LOOKUP.
- LOOKUP (1 cycle): cam_read=1, cam_check_tag=tag_q.
  - cam_found=1: capture data_q=cam_data, set hit_q=1, go to RESP.
  - Otherwise: go to MISS_REQ.
- MISS_REQ: mem_req_valid=1, mem_req_tag=tag_q, held until mem_req_ready; then MISS_WAIT. Same-cycle ready completes in one cycle.
- MISS_WAIT: on mem_rsp_valid capture data_q=mem_rsp_data, hit_q=0, go to FILL. A response arriving in MISS_REQ is ignored (protocol violation).
- FILL (1 cycle): cam_write_=0, cam_w_addr=victim, cam_wdata=data_q, cam_new_tag=tag_q, cam_new_valid=1; set shadow_valid[victim]; then RESP.
- Victim selection:
  - Lowest-index slot with shadow_valid=0.
  - If all slots are valid: victim=rr_ptr, and rr_ptr increments, wrapping WORDS-1 to 0.
  - rr_ptr is unchanged when an invalid slot is used.
- RESP (1 cycle): rsp_valid=1, rsp_hit=hit_q, rsp_data=data_q; then IDLE. No backpressure.
  - Hit latency: accept to rsp_valid = 2 cycles.
  - Miss with zero-wait memory: accept to rsp_valid = 5 cycles.
- FLUSH: one slot per cycle with cam_write_=0, cam_w_addr=counter, cam_new_valid=0, cam_new_tag=0, cam_wdata=0; clear shadow_valid[counter].
  - After slot WORDS-1: flush_done=1 for one cycle, rr_ptr=0, back to IDLE.
  - Takes WORDS cycles. req_ready=0 throughout.
- cam_write_ is 0 only in FILL and FLUSH.
- Assertion: shadow_valid == all-ones iff cam_full, checked one cycle after any write.

Decomposition:
- Package cam_ctrl_pkg:
  - state enum {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP, FLUSH}.
  - Width-helper function.
- Sub-module cam_victim_sel:
  - Inputs: shadow valid vector, rr_ptr.
  - Outputs: victim index, all_valid.
  - Pure combinational priority encoder plus mux.

Test Plan:
- Reset, then request tag 0x11 (miss); memory answers 0xA5 with zero wait -> mem_req_tag=0x11; FILL writes slot 0 (tag 0x11, valid 1); rsp_valid with hit=0, data=0xA5 exactly 5 cycles after accept.
- Repeat tag 0x11 -> rsp_hit=1, rsp_data=0xA5 two cycles after accept; no mem_req_valid.
- Fill 8 distinct tags 0x20-0x27 -> slots 0-7 in order; cam_full=1. Tag 0x30 -> slot 0; tag 0x31 -> slot 1 (rr_ptr wrap check after 8 more misses returns to slot 0).
- mem_req_ready held low 3 cycles, mem_rsp_valid delayed 4 cycles -> mem_req_valid and mem_req_tag stable throughout; req_ready=0 until RESP completes.
- flush_req and req_valid asserted together in IDLE -> flush wins; 8 writes with cam_new_valid=0 to addresses 0-7; flush_done pulse; the following lookup of a prior tag misses.
- rst_ asserted during MISS_WAIT -> immediate IDLE, all outputs at reset values, no rsp_valid; the next request is a miss filled into slot 0.
